sub_mean_window: RTL and testbench

Parametrised sliding-window mean-removal stage for the audio front end, sitting between the I2S FIFO read side and the ZCR/STE feature blocks. It keeps the last 2^LOG2_WIN samples in a circular buffer with a running sum and emits a delayed tap minus the window mean, with saturation. Unlike the fixed 16-sample version, it is sample-driven through a valid strobe, uses signed arithmetic, supports synchronous flush and flags saturation.

---
 rtl/sub_mean_window.sv | 80 ++++++++
 tb/tb_sub_mean_window.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sub_mean_window.sv
// sub_mean_window: sliding-window mean removal (delayed tap minus window mean) with optional saturation
// Ports: clk, reset (async, active-high); data_in + data_valid = sample input; clear = sync flush;
//        subMean_out/subMean_valid/sat_flag = registered result pulse; window_full = window primed.
module sub_mean_window #(
    parameter int DATA_WIDTH    = 16,
    parameter int LOG2_WIN      = 4,
    parameter int CENTER_OFFSET = 8,
    parameter bit SATURATE      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    input  logic                         clear,
    output logic signed [DATA_WIDTH-1:0] subMean_out,
    output logic                         subMean_valid,
    output logic                         sat_flag,
    output logic                         window_full
);
    localparam int W  = 1 << LOG2_WIN;
    localparam int SW = DATA_WIDTH + LOG2_WIN;
    typedef enum logic {FILL, RUN} state_t;
    state_t state, state_nxt;
    logic signed [DATA_WIDTH-1:0] mem [W];
    logic [LOG2_WIN-1:0] wr_ptr, rd_ptr;
    logic signed [SW-1:0] sum, sum_nxt, din_x, old_x;
    logic signed [DATA_WIDTH-1:0] tap, tap_nxt, mean, res;
    logic signed [DATA_WIDTH:0] diff;
    logic pend, accept, last_fill, emit, ovf;
    assign accept    = data_valid && !clear;
    assign last_fill = (wr_ptr == LOG2_WIN'(W - 1));
    assign emit      = accept && (state == RUN || last_fill);
    // Running sum: the sample leaving the window is read before it is overwritten; FILL never reads the buffer.
    assign din_x   = SW'(data_in);
    assign old_x   = (state == RUN) ? SW'(mem[wr_ptr]) : '0;
    assign sum_nxt = sum + din_x - old_x;
    assign rd_ptr  = wr_ptr - LOG2_WIN'(CENTER_OFFSET);
    assign tap_nxt = (CENTER_OFFSET == 0) ? data_in : mem[rd_ptr];
    // Dropping the low LOG2_WIN bits is an arithmetic shift: floor toward -inf.
    assign mean = sum[SW-1:LOG2_WIN];
    assign diff = {tap[DATA_WIDTH-1], tap} - {mean[DATA_WIDTH-1], mean};
    assign ovf  = diff[DATA_WIDTH] ^ diff[DATA_WIDTH-1];
    assign res  = (SATURATE && ovf)
                ? (diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                : diff[DATA_WIDTH-1:0];
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FILL;
        else state <= state_nxt;
    always_comb
        state_nxt = clear ? FILL : (state == FILL && accept && last_fill) ? RUN : state;
    always_comb
        window_full = (state == RUN);
    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr        <= '0;
            sum           <= '0;
            tap           <= '0;
            pend          <= 1'b0;
            subMean_out   <= '0;
            subMean_valid <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            subMean_valid <= pend && !clear;
            if (pend && !clear) begin
                subMean_out <= res;
                sat_flag    <= SATURATE && ovf;
            end
            pend <= emit;
            if (emit) tap <= tap_nxt;
            if (clear) begin
                wr_ptr <= '0;
                sum    <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + LOG2_WIN'(1);
                sum    <= sum_nxt;
            end
        end
endmodule

// File: tb/tb_sub_mean_window.sv
// tb_sub_mean_window: scoreboard bench driving three configurations of sub_mean_window with shared stimulus
module tb_sub_mean_window;
    typedef struct { int val; int sat; int due; } exp_t;
    logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0, clear = 1'b0;
    logic signed [15:0] data_in = '0;
    logic signed [15:0] o_o [3];
    logic v_o [3];
    logic s_o [3];
    logic wf [3];
    int lw [3] = '{4, 4, 2};
    int dd [3] = '{8, 8, 0};
    int sm [3] = '{1, 0, 1};
    exp_t q [3][$];
    int hist [$];
    int last [3];
    int total = 0, bad = 0, cycle = 0;

    always #5 clk = ~clk;

    sub_mean_window u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear(clear),
        .subMean_out(o_o[0]), .subMean_valid(v_o[0]), .sat_flag(s_o[0]), .window_full(wf[0])
    );
    sub_mean_window #(.SATURATE(1'b0)) u1 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear(clear),
        .subMean_out(o_o[1]), .subMean_valid(v_o[1]), .sat_flag(s_o[1]), .window_full(wf[1])
    );
    sub_mean_window #(.LOG2_WIN(2), .CENTER_OFFSET(0)) u2 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear(clear),
        .subMean_out(o_o[2]), .subMean_valid(v_o[2]), .sat_flag(s_o[2]), .window_full(wf[2])
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: mean of the last W accepted samples, floored, subtracted from x[k-D].
    task automatic model_push(input int i);
        int w, k, s, m, d, o, f;
        exp_t e;
        w = 1 << lw[i];
        k = hist.size() - 1;
        s = 0;
        if (k < w - 1) return;
        for (int j = k - w + 1; j <= k; j++) s += hist[j];
        m = s / w;
        if (s % w != 0 && s < 0) m--;
        d = hist[k - dd[i]] - m;
        if (sm[i] != 0) begin
            o = (d > 32767) ? 32767 : (d < -32768) ? -32768 : d;
            f = (o != d) ? 1 : 0;
        end else begin
            o = d & 32'hFFFF;
            if (o > 32767) o -= 65536;
            f = 0;
        end
        e.val = o;
        e.sat = f;
        e.due = cycle + 1;
        q[i].push_back(e);
    endtask

    task automatic score(input int i);
        bit due;
        exp_t e;
        due = (q[i].size() > 0) && (q[i][0].due == cycle);
        chk($sformatf("valid[%0d]@%0d", i, cycle), v_o[i], due);
        if (due) begin
            e = q[i].pop_front();
            if (v_o[i]) begin
                chk($sformatf("out[%0d]@%0d", i, cycle), o_o[i], e.val);
                chk($sformatf("sat[%0d]@%0d", i, cycle), s_o[i], e.sat);
                last[i] = e.val;
            end
        end else
            chk($sformatf("hold[%0d]@%0d", i, cycle), o_o[i], last[i]);
        chk($sformatf("full[%0d]@%0d", i, cycle), wf[i], hist.size() >= (1 << lw[i]));
    endtask

    task automatic step(input logic v, input logic signed [15:0] d, input logic c);
        data_valid = v;
        data_in    = d;
        clear      = c;
        @(posedge clk);
        cycle++;
        if (c) begin
            hist.delete();
            for (int i = 0; i < 3; i++) q[i].delete();
        end else if (v) begin
            hist.push_back(int'(d));
            for (int i = 0; i < 3; i++) model_push(i);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) score(i);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            last[i] = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out[%0d]", i), o_o[i], 0);
            chk($sformatf("rst_valid[%0d]", i), v_o[i], 0);
            chk($sformatf("rst_sat[%0d]", i), s_o[i], 0);
            chk($sformatf("rst_full[%0d]", i), wf[i], 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        for (int n = 0; n < 16; n++) step(1'b1, 16'sd100, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        chk("dc100_out", o_o[0], 0);
        chk("dc100_sat", s_o[0], 0);
        chk("dc100_full", wf[0], 1);

        step(1'b0, 16'sd0, 1'b1);
        for (int n = 0; n < 15; n++) step(1'b1, 16'sd0, 1'b0);
        step(1'b1, -16'sd1, 1'b0);
        step(1'b1, -16'sd1, 1'b0);
        chk("floor_plus1", o_o[0], 1);
        for (int n = 0; n < 15; n++) step(1'b1, -16'sd1, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        chk("neg1_zero", o_o[0], 0);

        do_reset();
        for (int n = 0; n < 8; n++) step(1'b1, 16'sd32767, 1'b0);
        for (int n = 0; n < 8; n++) step(1'b1, -16'sd32768, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        chk("sat_out", o_o[0], 32767);
        chk("sat_flag", s_o[0], 1);
        chk("wrap_out", o_o[1], -32768);
        chk("wrap_flag", s_o[1], 0);

        step(1'b0, 16'sd0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 16'(n), 1'b0);
            step(1'b0, 16'sd0, 1'b0);
            if (n == 15) chk("ramp_k15", o_o[0], 0);
        end

        step(1'b0, 16'sd0, 1'b1);
        for (int n = 0; n < 20; n++) step(1'b1, 16'(1000 + 37 * n), 1'b0);
        step(1'b1, 16'sd555, 1'b1);
        chk("clr_kill", v_o[0], 0);
        chk("clr_full", wf[0], 0);
        for (int n = 0; n < 16; n++) step(1'b1, 16'(10 * n), 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        chk("clr_out", o_o[0], -5);

        do_reset();
        step(1'b1, 16'sd4, 1'b0);
        step(1'b1, 16'sd8, 1'b0);
        step(1'b1, 16'sd12, 1'b0);
        step(1'b1, 16'sd16, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        chk("d0_out", o_o[2], 6);
        step(1'b1, 16'sd20, 1'b0);
        step(1'b1, 16'sd24, 1'b0);
        do_reset();
        for (int n = 0; n < 5; n++) step(1'b1, 16'sd5, 1'b0);
        step(1'b0, 16'sd0, 1'b0);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic v, c;
            logic signed [15:0] d;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) < 2);
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 400)) - 200);
            step(v, d, c);
        end
        step(1'b0, 16'sd0, 1'b0);
        step(1'b0, 16'sd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
